// File: rtl/commutation_pkg.sv
// Shared encodings for the matrix-converter commutation monitor: gate patterns, load codes,
// pattern classes and fault codes.
package commutation_pkg;

  // Gate vector is {Ap,An,Bp,Bn,Cp,Cn}
  localparam logic [5:0] FULL_A   = 6'b110000;
  localparam logic [5:0] FULL_B   = 6'b001100;
  localparam logic [5:0] FULL_C   = 6'b000011;
  localparam logic [5:0] POS_MASK = 6'b101010;
  localparam logic [5:0] NEG_MASK = 6'b010101;

  // Matches the commutation FSM DesiredLoad encoding
  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_A    = 2'b01;
  localparam logic [1:0] LOAD_B    = 2'b10;
  localparam logic [1:0] LOAD_C    = 2'b11;

  typedef enum logic [2:0] {
    ClsNone    = 3'd0,
    ClsSingle  = 3'd1,
    ClsOverlap = 3'd2,
    ClsFull    = 3'd3,
    ClsIllegal = 3'd4
  } pat_class_e;

  typedef enum logic [3:0] {
    FltNone        = 4'd0,
    FltIllegal     = 4'd1,
    FltMultiStep   = 4'd2,
    FltOpenCircuit = 4'd3,
    FltSignErr     = 4'd4,
    FltDwellShort  = 4'd5,
    FltStuck       = 4'd6
  } fault_code_e;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gate_pattern_classifier.sv
// Combinational decode of a 6-bit gate vector into pattern class, source phase and polarity.
module gate_pattern_classifier
  import commutation_pkg::*;
(
  input  logic [5:0] gate_i,
  output logic [2:0] class_o,
  output logic [1:0] phase_o,
  output logic       polarity_o
);

  logic [2:0] ones;

  always_comb begin
    ones       = popcount6(gate_i);
    class_o    = ClsIllegal;
    polarity_o = |(gate_i & POS_MASK);
    if (gate_i[5:4] != 2'b00) begin
      phase_o = LOAD_A;
    end else if (gate_i[3:2] != 2'b00) begin
      phase_o = LOAD_B;
    end else if (gate_i[1:0] != 2'b00) begin
      phase_o = LOAD_C;
    end else begin
      phase_o = LOAD_NONE;
    end

    if (gate_i == 6'b000000) begin
      class_o = ClsNone;
    end else if (gate_i == FULL_A || gate_i == FULL_B || gate_i == FULL_C) begin
      class_o = ClsFull;
    end else if (ones == 3'd1) begin
      class_o = ClsSingle;
    end else if (ones == 3'd2 && ((gate_i & POS_MASK) == 6'b0 || (gate_i & NEG_MASK) == 6'b0)) begin
      // Two same-polarity bits can only sit on different phases
      class_o = ClsOverlap;
    end
  end

endmodule

// File: rtl/commutation_monitor.sv
// Checks one output leg's gate vector against the 4-step commutation rules, latches the first
// fault and counts completed commutations.
module commutation_monitor
  import commutation_pkg::*;
#(
  parameter int unsigned MIN_OFF_DWELL = 10,
  parameter int unsigned MIN_ON_DWELL  = 2,
  parameter int unsigned MAX_TRANSIENT = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  gate_in_i,
  input  logic        current_sign_i,
  input  logic        fault_clr_i,
  output logic [1:0]  load_phase_o,
  output logic        load_valid_o,
  output logic [2:0]  pattern_class_o,
  output logic        commutation_done_o,
  output logic [15:0] comm_count_o,
  output logic        fault_o,
  output logic        fault_pulse_o,
  output logic [3:0]  fault_code_o
);

  localparam logic [CNT_W:0] MinOffW = (CNT_W + 1)'(MIN_OFF_DWELL);
  localparam logic [CNT_W:0] MinOnW  = (CNT_W + 1)'(MIN_ON_DWELL);
  localparam logic [CNT_W:0] MaxTrW  = (CNT_W + 1)'(MAX_TRANSIENT);

  logic [5:0]       g_cur_q, g_prev_q;
  logic             s_cur_q;
  logic [2:0]       cls_cur, cls_prev_q;
  logic [1:0]       phase_cur;
  logic             pol_cur;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W:0]   dwell_inc;
  logic             changed, stuck, done_d;
  logic [3:0]       fault_det;
  logic             fault_d;
  logic [3:0]       fault_code_d;

  gate_pattern_classifier u_classifier (
    .gate_i     (g_cur_q),
    .class_o    (cls_cur),
    .phase_o    (phase_cur),
    .polarity_o (pol_cur)
  );

  always_comb begin
    changed   = g_cur_q != g_prev_q;
    dwell_inc = {1'b0, dwell_q} + 1'b1;
    dwell_d   = changed ? '0 : (&dwell_q ? dwell_q : dwell_q + 1'b1);
    // dwell_q belongs to the previous pattern on a change cycle, so only test it when held
    stuck     = !changed && (cls_cur == ClsSingle || cls_cur == ClsOverlap) &&
                dwell_inc == MaxTrW;
    done_d    = changed && cls_cur == ClsFull && phase_cur != load_phase_o &&
                load_phase_o != LOAD_NONE;

    fault_det = FltNone;
    if (cls_cur == ClsIllegal) begin
      fault_det = FltIllegal;
    end else if (changed && cls_prev_q != ClsNone && popcount6(g_cur_q ^ g_prev_q) > 3'd1) begin
      fault_det = FltMultiStep;
    end else if (changed && g_cur_q == 6'b000000) begin
      fault_det = FltOpenCircuit;
    end else if (changed && cls_prev_q == ClsFull && cls_cur == ClsSingle &&
                 pol_cur != s_cur_q) begin
      // The switch left on must be the one matching the current direction
      fault_det = FltSignErr;
    end else if (changed && ((cls_prev_q == ClsSingle && dwell_inc < MinOffW) ||
                             (cls_prev_q == ClsOverlap && dwell_inc < MinOnW))) begin
      fault_det = FltDwellShort;
    end else if (stuck) begin
      fault_det = FltStuck;
    end

    fault_d      = fault_o;
    fault_code_d = fault_code_o;
    if (fault_det != FltNone) begin
      if (!fault_o) begin
        fault_d      = 1'b1;
        fault_code_d = fault_det;
      end
    end else if (fault_clr_i) begin
      fault_d      = 1'b0;
      fault_code_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      g_cur_q            <= '0;
      g_prev_q           <= '0;
      s_cur_q            <= 1'b0;
      cls_prev_q         <= ClsNone;
      dwell_q            <= '0;
      load_phase_o       <= LOAD_NONE;
      load_valid_o       <= 1'b0;
      pattern_class_o    <= ClsNone;
      commutation_done_o <= 1'b0;
      comm_count_o       <= '0;
      fault_o            <= 1'b0;
      fault_pulse_o      <= 1'b0;
      fault_code_o       <= 4'd0;
    end else begin
      g_cur_q            <= gate_in_i;
      g_prev_q           <= g_cur_q;
      s_cur_q            <= current_sign_i;
      cls_prev_q         <= cls_cur;
      dwell_q            <= dwell_d;
      load_valid_o       <= cls_cur == ClsFull;
      pattern_class_o    <= cls_cur;
      if (cls_cur == ClsFull) load_phase_o <= phase_cur;
      commutation_done_o <= done_d;
      if (done_d) comm_count_o <= comm_count_o + 16'd1;
      fault_o            <= fault_d;
      fault_pulse_o      <= fault_det != FltNone;
      fault_code_o       <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_commutation_monitor.sv
// Directed bench for commutation_monitor with hand-computed expectations.
module tb_commutation_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  gate_in;
  logic        current_sign;
  logic        fault_clr;
  logic [1:0]  load_phase;
  logic        load_valid;
  logic [2:0]  pattern_class;
  logic        commutation_done;
  logic [15:0] comm_count;
  logic        fault;
  logic        fault_pulse;
  logic [3:0]  fault_code;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;
  int pulse_cnt  = 0;

  always #5 clk = ~clk;

  commutation_monitor dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .gate_in_i          (gate_in),
    .current_sign_i     (current_sign),
    .fault_clr_i        (fault_clr),
    .load_phase_o       (load_phase),
    .load_valid_o       (load_valid),
    .pattern_class_o    (pattern_class),
    .commutation_done_o (commutation_done),
    .comm_count_o       (comm_count),
    .fault_o            (fault),
    .fault_pulse_o      (fault_pulse),
    .fault_code_o       (fault_code)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [5:0] g, input int n);
    gate_in = g;
    for (int i = 0; i < n; i++) begin
      step();
      done_cnt  += int'(commutation_done);
      pulse_cnt += int'(fault_pulse);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    gate_in   = 6'b000000;
    fault_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; gate_in = 6'b110000; current_sign = 1'b1; fault_clr = 1'b0;
    repeat (3) step();
    vectors++;
    if ({load_phase, load_valid, pattern_class, commutation_done, comm_count, fault,
         fault_pulse, fault_code} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ph=%0d v=%0d cls=%0d done=%0d cnt=%0d f=%0d fp=%0d fc=%0d want all 0",
               load_phase, load_valid, pattern_class, commutation_done, comm_count, fault,
               fault_pulse, fault_code);
    end
    rst = 1'b0;
    step();
    step();
    vectors++;
    if (load_phase !== 2'b01 || load_valid !== 1'b1 || comm_count !== 16'd0) begin
      miscompares++;
      $display("FAIL startup_full_a: got ph=%0d v=%0d cnt=%0d want ph=1 v=1 cnt=0",
               load_phase, load_valid, comm_count);
    end
    vectors++;
    if (pattern_class !== 3'd3 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL startup_class: got cls=%0d f=%0d want cls=3 f=0", pattern_class, fault);
    end
  endtask

  task automatic test_commutation_sign1();
    current_sign = 1'b1; done_cnt = 0; pulse_cnt = 0;
    apply(6'b110000, 5);
    apply(6'b100000, 10);
    apply(6'b101000, 2);
    apply(6'b001000, 10);
    apply(6'b001100, 4);
    vectors++;
    if (load_phase !== 2'b10 || comm_count !== 16'd1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL sign1_commutation: got ph=%0d cnt=%0d pulses=%0d want ph=2 cnt=1 pulses=1",
               load_phase, comm_count, done_cnt);
    end
    vectors++;
    if (fault !== 1'b0 || pulse_cnt != 0) begin
      miscompares++;
      $display("FAIL sign1_no_fault: got f=%0d fault_pulses=%0d want 0 0", fault, pulse_cnt);
    end
  endtask

  task automatic test_sign_err();
    do_reset();
    current_sign = 1'b0;
    apply(6'b110000, 4);
    apply(6'b010000, 3);
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++;
      $display("FAIL sign0_keep_neg: got f=%0d code=%0d want f=0", fault, fault_code);
    end
    do_reset();
    current_sign = 1'b1;
    apply(6'b110000, 4);
    gate_in = 6'b010000;
    step();
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++;
      $display("FAIL sign_err_latency: got f=%0d want 0", fault);
    end
    step();
    vectors++;
    if (fault !== 1'b1 || fault_code !== 4'd4 || fault_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL sign_err: got f=%0d code=%0d fp=%0d want 1 4 1", fault, fault_code,
               fault_pulse);
    end
    step();
    vectors++;
    if (fault_pulse !== 1'b0 || fault !== 1'b1) begin
      miscompares++;
      $display("FAIL sign_err_pulse_width: got fp=%0d f=%0d want fp=0 f=1", fault_pulse, fault);
    end
  endtask

  task automatic test_dwell_short();
    do_reset();
    apply(6'b100000, 9);
    apply(6'b101000, 3);
    vectors++;
    if (fault !== 1'b1 || fault_code !== 4'd5) begin
      miscompares++;
      $display("FAIL dwell_short: got f=%0d code=%0d want 1 5", fault, fault_code);
    end
  endtask

  task automatic test_illegal_clr();
    do_reset();
    fault_clr = 1'b1;
    apply(6'b101100, 4);
    fault_clr = 1'b0;
    vectors++;
    if (fault !== 1'b1 || fault_code !== 4'd1 || pattern_class !== 3'd4) begin
      miscompares++;
      $display("FAIL illegal_vs_clr: got f=%0d code=%0d cls=%0d want 1 1 4", fault, fault_code,
               pattern_class);
    end
    apply(6'b000011, 5);
    vectors++;
    if (fault_code !== 4'd1) begin
      miscompares++;
      $display("FAIL first_fault_kept: got code=%0d want 1", fault_code);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    vectors++;
    if (fault !== 1'b0 || fault_code !== 4'd0 || load_phase !== 2'b11) begin
      miscompares++;
      $display("FAIL fault_clear: got f=%0d code=%0d ph=%0d want 0 0 3", fault, fault_code,
               load_phase);
    end
  endtask

  task automatic test_stuck();
    do_reset();
    gate_in = 6'b101000;
    repeat (65) step();
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_early: got f=%0d code=%0d want f=0", fault, fault_code);
    end
    step();
    vectors++;
    if (fault !== 1'b1 || fault_code !== 4'd6 || fault_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck: got f=%0d code=%0d fp=%0d want 1 6 1", fault, fault_code,
               fault_pulse);
    end
  endtask

  task automatic test_open_circuit();
    do_reset();
    apply(6'b001000, 3);
    apply(6'b000000, 3);
    vectors++;
    if (fault !== 1'b1 || fault_code !== 4'd3) begin
      miscompares++;
      $display("FAIL open_circuit: got f=%0d code=%0d want 1 3", fault, fault_code);
    end
  endtask

  task automatic test_multi_step();
    do_reset();
    current_sign = 1'b1;
    apply(6'b110000, 3);
    done_cnt = 0;
    apply(6'b001100, 3);
    vectors++;
    if (fault_code !== 4'd2 || comm_count !== 16'd1 || done_cnt != 1 || load_phase !== 2'b10)
    begin
      miscompares++;
      $display("FAIL multi_step: got code=%0d cnt=%0d pulses=%0d ph=%0d want 2 1 1 2",
               fault_code, comm_count, done_cnt, load_phase);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(6'b110000, 3);
    apply(6'b100000, 4);
    do_reset();
    vectors++;
    if (load_phase !== 2'b00 || comm_count !== 16'd0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got ph=%0d cnt=%0d f=%0d want 0 0 0", load_phase,
               comm_count, fault);
    end
    apply(6'b101000, 3);
    vectors++;
    if (fault !== 1'b0 || pattern_class !== 3'd2) begin
      miscompares++;
      $display("FAIL reset_mid_restart: got f=%0d code=%0d cls=%0d want f=0 cls=2", fault,
               fault_code, pattern_class);
    end
  endtask

  initial begin
    test_reset();
    test_commutation_sign1();
    test_sign_err();
    test_dwell_short();
    test_illegal_clr();
    test_stuck();
    test_open_circuit();
    test_multi_step();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
